// File: rtl/dma_priority_arbiter_pkg.sv
// Shared definitions for the DMA channel arbiter: FSM state encoding,
// the channel-count ceiling and a modulo-increment helper used when the
// rotating-priority pointer advances past the last channel.
package DmaPackage;

  // Largest channel count the arbiter is meant to be built with.
  localparam int DMA_MAX_CH = 8;

  // Index width able to hold any channel number up to DMA_MAX_CH-1.
  localparam int DMA_CH_W_MAX = $clog2(DMA_MAX_CH);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_REQ   = 2'd1,
    ARB_SERVE = 2'd2
  } arb_state_e;

  // Modulo increment with an explicit wrap, so it stays correct when
  // num_ch is not a power of two (plain +1 would run past the last channel).
  function automatic logic [DMA_CH_W_MAX-1:0] dma_wrap_inc(
    input logic [DMA_CH_W_MAX-1:0] val,
    input int                      num_ch
  );
    if (int'(val) >= num_ch - 1) begin
      return '0;
    end
    return val + 1'b1;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Bundle of the arbiter's request, configuration, bus-hold and acknowledge
// signals. The slave view belongs to the arbiter; the master view belongs
// to whoever drives the pins and configuration (register block / CPU side).
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  // Raw request pins and request qualification controls
  logic [NUM_CH-1:0] DREQ;
  logic              dreqActiveLow;
  logic              dackActiveHigh;
  logic              rotatingPriority;
  logic              ctrlDisable;
  logic [NUM_CH-1:0] maskBits;
  logic [NUM_CH-1:0] swRequest;

  // Bus-hold handshake and end-of-service strobe
  logic              HLDA;
  logic              xferDone;
  logic              HRQ;

  // Grant outputs
  logic [NUM_CH-1:0] DACK;
  logic              grantValid;
  logic [CH_W-1:0]   activeCh;

  modport master (
    output DREQ, dreqActiveLow, dackActiveHigh, rotatingPriority,
           ctrlDisable, maskBits, swRequest, HLDA, xferDone,
    input  HRQ, DACK, grantValid, activeCh
  );

  modport slave (
    input  DREQ, dreqActiveLow, dackActiveHigh, rotatingPriority,
           ctrlDisable, maskBits, swRequest, HLDA, xferDone,
    output HRQ, DACK, grantValid, activeCh
  );

endinterface

// File: rtl/dma_priority_arbiter_rr_pick.sv
// dma_rr_pick: combinational priority picker. topPtr names the channel
// with the highest priority; priority then falls with increasing index,
// wrapping from NUM_CH-1 back to 0. Driving topPtr with 0 gives plain
// fixed priority (channel 0 highest).
module dma_rr_pick
  import DmaPackage::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   topPtr,
  output logic [CH_W-1:0]   winner,
  output logic              anyReq
);

  // Channel index found 'off' places below the top of the priority order.
  function automatic logic [CH_W-1:0] wrap_add(
    input logic [CH_W-1:0] base,
    input int              off
  );
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CH) begin
      sum = sum - NUM_CH;
    end
    return CH_W'(sum);
  endfunction

  // rot_req[k] is the request of the channel at priority rank k (0 = top).
  logic [NUM_CH-1:0] rot_req;
  logic [CH_W-1:0]   rot_idx [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rank
      assign rot_idx[gi] = wrap_add(topPtr, gi);
      assign rot_req[gi] = req[rot_idx[gi]];
    end
  endgenerate

  // Lowest rank with a pending request wins; scanning downwards lets the
  // last assignment be the highest-priority hit.
  always_comb begin
    winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        winner = rot_idx[i];
      end
    end
  end

  assign anyReq = |req;

endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: qualifies raw DREQ pins with polarity, mask and
// software requests, runs the HRQ/HLDA bus-hold handshake and grants one
// channel at a time until the timing-control block pulses xferDone.
// Optional feature macro: DMA_ROTATING_PRIORITY_EN builds the rotating
// priority pointer; without it arbitration is always fixed (channel 0 first)
// and rotatingPriority is ignored.
module dma_priority_arbiter
  import DmaPackage::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dma_priority_arbiter_if.slave  bus
);

  logic [NUM_CH-1:0] eff_req;
  logic [NUM_CH-1:0] req_reg;
  logic [NUM_CH-1:0] ack_vec;

  arb_state_e        state_reg;
  arb_state_e        state_next;
  logic              hrq_reg;
  logic              grant_reg;
  logic [CH_W-1:0]   active_ch_reg;

  logic [CH_W-1:0]   pick_top;
  logic [CH_W-1:0]   pick_winner;
  logic              pick_any;
  logic              latch_grant;
  logic              rotate_en;

  // Software requests bypass both the pin polarity and the hardware mask;
  // the controller disable gates everything.
  assign eff_req = (((bus.DREQ ^ {NUM_CH{bus.dreqActiveLow}}) & ~bus.maskBits)
                    | bus.swRequest) & {NUM_CH{~bus.ctrlDisable}};

  // Sample qualified requests every cycle; arbitration only looks at this copy.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      req_reg <= '0;
    end else begin
      req_reg <= eff_req;
    end
  end

  dma_rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req    (req_reg),
    .topPtr (pick_top),
    .winner (pick_winner),
    .anyReq (pick_any)
  );

  // Next-state logic for the hold handshake and service phases.
  always_comb begin
    state_next  = state_reg;
    latch_grant = 1'b0;
    rotate_en   = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_REQ;
        end
      end
      ARB_REQ: begin
        // A withdrawn request drops back to idle even if HLDA already arrived.
        if (!pick_any) begin
          state_next = ARB_IDLE;
        end else if (bus.HLDA) begin
          latch_grant = 1'b1;
          state_next  = ARB_SERVE;
        end
      end
      ARB_SERVE: begin
        // Completion takes precedence over a simultaneous HLDA drop.
        if (bus.xferDone) begin
          rotate_en  = 1'b1;
          state_next = ARB_IDLE;
        end else if (!bus.HLDA) begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // State, hold request and grant flag registers; HRQ and grantValid are
  // decoded from the next state so they come straight out of flops.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ARB_IDLE;
      hrq_reg   <= 1'b0;
      grant_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      hrq_reg   <= (state_next != ARB_IDLE);
      grant_reg <= (state_next == ARB_SERVE);
    end
  end

  // Winner is frozen at grant time so request changes during service
  // cannot move the acknowledge to another channel.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      active_ch_reg <= '0;
    end else if (latch_grant) begin
      active_ch_reg <= pick_winner;
    end
  end

`ifdef DMA_ROTATING_PRIORITY_EN
  logic [CH_W-1:0] top_ptr_reg;

  // Rotating pointer: after a completed service the channel just served
  // drops to lowest priority. Aborted services leave it alone, and fixed
  // mode pins it at 0 so re-entering rotating mode starts from channel 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      top_ptr_reg <= '0;
    end else if (!bus.rotatingPriority) begin
      top_ptr_reg <= '0;
    end else if (rotate_en) begin
      top_ptr_reg <= CH_W'(dma_wrap_inc(DMA_CH_W_MAX'(active_ch_reg), NUM_CH));
    end
  end

  assign pick_top = top_ptr_reg;
`else
  // Fixed priority only: the mode input and rotation strobe have no effect.
  logic unused_rotation;
  assign unused_rotation = rotate_en ^ bus.rotatingPriority;
  assign pick_top        = '0;
`endif

  // One-hot acknowledge of the serviced channel, all zero outside service.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ack
      assign ack_vec[gi] = grant_reg && (active_ch_reg == CH_W'(gi));
    end
  endgenerate

  assign bus.DACK       = bus.dackActiveHigh ? ack_vec : ~ack_vec;
  assign bus.HRQ        = hrq_reg;
  assign bus.grantValid = grant_reg;
  assign bus.activeCh   = active_ch_reg;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter: a 4-channel and a 3-channel
// instance share clock and reset. Stimulus pushes expected grants into a
// queue per instance; monitors pop and compare on each new grant.
module tb_dma_priority_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dma_priority_arbiter_if #(.NUM_CH(4)) if4 ();
  dma_priority_arbiter_if #(.NUM_CH(3)) if3 ();

  dma_priority_arbiter #(.NUM_CH(4)) u4 (.CLK(clk), .RESET(rst), .bus(if4));
  dma_priority_arbiter #(.NUM_CH(3)) u3 (.CLK(clk), .RESET(rst), .bus(if3));

  typedef struct {
    int         ch;
    logic [3:0] dack;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Grant monitors: each rising grantValid must match the oldest expectation.
  logic gv4_prev = 1'b0;
  logic gv3_prev = 1'b0;

  always @(negedge clk) begin : mon4
    exp_t e;
    if (if4.grantValid && !gv4_prev) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL grant4_unexpected actual=ch%0d required=no grant", if4.activeCh);
      end else begin
        e = q4.pop_front();
        $display("grant dut4 ch=%0d dack=%b expect ch=%0d dack=%b",
                 if4.activeCh, if4.DACK, e.ch, e.dack);
        chk("grant4_ch", 32'(if4.activeCh), 32'(e.ch));
        chk("grant4_dack", 32'(if4.DACK), 32'(e.dack));
      end
    end
    gv4_prev = if4.grantValid;
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (if3.grantValid && !gv3_prev) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL grant3_unexpected actual=ch%0d required=no grant", if3.activeCh);
      end else begin
        e = q3.pop_front();
        $display("grant dut3 ch=%0d dack=%b expect ch=%0d dack=%b",
                 if3.activeCh, if3.DACK, e.ch, e.dack[2:0]);
        chk("grant3_ch", 32'(if3.activeCh), 32'(e.ch));
        chk("grant3_dack", 32'(if3.DACK), 32'(e.dack[2:0]));
      end
    end
    gv3_prev = if3.grantValid;
  end

  task automatic push(input int sel, input int ch, input logic [3:0] dack);
    exp_t e;
    e.ch   = ch;
    e.dack = dack;
    if (sel == 4) q4.push_back(e);
    else          q3.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic hrq_of(input int sel);
    return (sel == 4) ? if4.HRQ : if3.HRQ;
  endfunction

  task automatic set_hlda(input int sel, input logic v);
    if (sel == 4) if4.HLDA = v;
    else          if3.HLDA = v;
  endtask

  task automatic set_xfer(input int sel, input logic v);
    if (sel == 4) if4.xferDone = v;
    else          if3.xferDone = v;
  endtask

  task automatic wait_hrq(input int sel);
    int n;
    n = 0;
    while (!hrq_of(sel) && n < 20) begin
      tick(1);
      n++;
    end
    total++;
    if (!hrq_of(sel)) begin
      bad++;
      $display("FAIL hrq_wait dut%0d actual=low after %0d cycles required=high", sel, n);
    end
  endtask

  // CPU grants the bus, service lasts 'hold' cycles, then timing control
  // signals completion and the CPU releases the bus.
  task automatic serve(input int sel, input int hold);
    wait_hrq(sel);
    set_hlda(sel, 1'b1);
    tick(1);
    tick(hold);
    set_xfer(sel, 1'b1);
    tick(1);
    set_xfer(sel, 1'b0);
    set_hlda(sel, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rot_exp [5];
    int third3;
`ifdef DMA_ROTATING_PRIORITY_EN
    rot_exp = '{0, 1, 2, 3, 0};
    third3  = 2;
`else
    rot_exp = '{0, 0, 0, 0, 0};
    third3  = 0;
`endif

    rst = 1'b1;
    if4.DREQ = '0; if4.dreqActiveLow = 1'b0; if4.dackActiveHigh = 1'b1;
    if4.rotatingPriority = 1'b0; if4.ctrlDisable = 1'b0; if4.maskBits = '0;
    if4.swRequest = '0; if4.HLDA = 1'b0; if4.xferDone = 1'b0;
    if3.DREQ = '0; if3.dreqActiveLow = 1'b0; if3.dackActiveHigh = 1'b1;
    if3.rotatingPriority = 1'b0; if3.ctrlDisable = 1'b0; if3.maskBits = '0;
    if3.swRequest = '0; if3.HLDA = 1'b0; if3.xferDone = 1'b0;
    tick(2);

    // Reset state
    chk("reset_hrq", 32'(if4.HRQ), 32'd0);
    chk("reset_grant", 32'(if4.grantValid), 32'd0);
    chk("reset_activech", 32'(if4.activeCh), 32'd0);
    chk("reset_dack4", 32'(if4.DACK), 32'h0);
    chk("reset_dack3", 32'(if3.DACK), 32'h0);
    rst = 1'b0;
    tick(2);

    // Fixed priority, 2-cycle HRQ latency, then next grant to channel 3
    if4.DREQ = 4'b1010;
    push(4, 1, 4'b0010);
    tick(1);
    chk("latency_hrq_edge0", 32'(if4.HRQ), 32'd0);
    tick(1);
    chk("latency_hrq_edge1", 32'(if4.HRQ), 32'd1);
    if4.HLDA = 1'b1;
    tick(1);
    if4.DREQ = 4'b1000;
    push(4, 3, 4'b1000);
    tick(1);
    if4.xferDone = 1'b1;
    tick(1);
    if4.xferDone = 1'b0;
    if4.HLDA = 1'b0;
    chk("done_hrq_low", 32'(if4.HRQ), 32'd0);
    chk("done_dack_idle", 32'(if4.DACK), 32'h0);
    serve(4, 1);
    if4.DREQ = '0;
    tick(4);

    // Rotating request sweep with all four channels requesting
    if4.rotatingPriority = 1'b1;
    if4.DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      push(4, rot_exp[i], 4'b0001 << rot_exp[i]);
      serve(4, 1);
    end
    if4.DREQ = '0;
    if4.rotatingPriority = 1'b0;
    tick(4);

    // Active-low pins fully masked: no hold request
    if4.dreqActiveLow = 1'b1;
    if4.DREQ = 4'b1110;
    if4.maskBits = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("masked_no_hrq", 32'(if4.HRQ), 32'd0);
    end
    // Software request bypasses mask and polarity
    if4.swRequest = 4'b0001;
    push(4, 0, 4'b0001);
    tick(1);
    chk("sw_hrq_edge0", 32'(if4.HRQ), 32'd0);
    tick(1);
    chk("sw_hrq_edge1", 32'(if4.HRQ), 32'd1);
    serve(4, 2);
    if4.swRequest = '0;
    if4.dreqActiveLow = 1'b0;
    if4.DREQ = '0;
    if4.maskBits = '0;
    tick(4);

    // Active-low DACK, abort by HLDA drop leaves the pointer alone
    if4.dackActiveHigh = 1'b0;
    if4.rotatingPriority = 1'b1;
    #1;
    chk("dack_low_idle", 32'(if4.DACK), 32'hf);
    if4.DREQ = 4'b0100;
    push(4, 2, 4'b1011);
    wait_hrq(4);
    if4.HLDA = 1'b1;
    tick(2);
    if4.HLDA = 1'b0;
    if4.DREQ = '0;
    tick(1);
    chk("abort_dack", 32'(if4.DACK), 32'hf);
    chk("abort_hrq", 32'(if4.HRQ), 32'd0);
    chk("abort_grant", 32'(if4.grantValid), 32'd0);
    tick(3);
    if4.DREQ = 4'b1111;
    push(4, 0, 4'b1110);
    serve(4, 1);
    if4.DREQ = '0;
    if4.rotatingPriority = 1'b0;
    if4.dackActiveHigh = 1'b1;
    tick(4);

    // Three-channel instance: wrap after channel 2, then async reset mid-service
    if3.rotatingPriority = 1'b1;
    if3.DREQ = 3'b100;
    push(3, 2, 4'b0100);
    serve(3, 1);
    if3.DREQ = 3'b101;
    push(3, 0, 4'b0001);
    serve(3, 1);
    push(3, third3, 4'b0001 << third3);
    serve(3, 1);
    push(3, 0, 4'b0001);
    wait_hrq(3);
    if3.HLDA = 1'b1;
    tick(1);
    #6;
    chk("pre_reset_grant3", 32'(if3.grantValid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_hrq3", 32'(if3.HRQ), 32'd0);
    chk("async_reset_dack3", 32'(if3.DACK), 32'h0);
    chk("async_reset_grant3", 32'(if3.grantValid), 32'd0);
    tick(1);
    rst = 1'b0;
    if3.HLDA = 1'b0;
    if3.DREQ = '0;
    tick(3);

    chk("queue4_drained", 32'(q4.size()), 32'd0);
    chk("queue3_drained", 32'(q3.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Parametrised DMA channel arbiter that replaces the fixed 4-channel priority logic. It:
- qualifies raw `DREQ` pins with polarity, mask and software requests;
- runs the `HRQ`/`HLDA` bus-hold handshake;
- selects one channel under fixed or rotating priority and drives polarity-corrected `DACK` until the timing-control block signals end of service.

It sits between the command/mask/request register block and the transfer timing control.

## Interface
- `NUM_CH`, 4, number of channels (2..8); `CH_W = $clog2(NUM_CH)`
- `CLK`  in  1  system clock; all state updates on rising edge
- `RESET`  in  1  asynchronous, active-high reset
- `DREQ`  in  NUM_CH  raw channel request pins
- `dreqActiveLow`  in  1  1: `DREQ` active-low; 0: active-high
- `dackActiveHigh`  in  1  1: `DACK` active-high; 0: active-low
- `rotatingPriority`  in  1  1: rotating mode; 0: fixed mode
- `ctrlDisable`  in  1  controller disable; blocks new requests
- `maskBits`  in  NUM_CH  per-channel hardware request mask; 1 = masked
- `swRequest`  in  NUM_CH  per-channel software request bits
- `HLDA`  in  1  hold acknowledge from CPU
- `xferDone`  in  1  one-cycle pulse from timing control: service of the active channel complete
- `HRQ`  out  1  hold request to CPU
- `DACK`  out  NUM_CH  channel acknowledge, polarity per `dackActiveHigh`
- `grantValid`  out  1  a channel is being serviced
- `activeCh`  out  CH_W  index of the serviced channel; valid while `grantValid`

## Operation
- Effective request, per channel: `hwReq = (DREQ ^ {NUM_CH{dreqActiveLow}}) & ~maskBits`.
  - `effReq = (hwReq | swRequest) & {NUM_CH{~ctrlDisable}}`.
  - Software requests ignore mask and polarity.
- `reqReg` registers `effReq` every cycle. Arbitration uses only `reqReg`.
- State machine `ARB_IDLE`, `ARB_REQ`, `ARB_SERVE`:
  - **IDLE**: if `|reqReg`, go to REQ.
  - **REQ**:
    - If `reqReg == 0` and `HLDA == 0`, return to IDLE (request withdrawn).
    - Else if `HLDA`: latch winner into `activeCh`; go to SERVE.
    - If `HLDA` is high but `reqReg == 0`, return to IDLE.
  - **SERVE**:
    - On `xferDone`: go to IDLE and apply rotation.
    - On `HLDA` deasserted: go to IDLE, no rotation (abort).
    - If both occur in the same cycle, treat it as `xferDone`.
- `HRQ = 1` in REQ and SERVE. Registered.
- Internal `ackVec`: one-hot of `activeCh` in SERVE, else 0.
  - `DACK = dackActiveHigh ? ackVec : ~ackVec`.
  - This is the only combinational output path.
- Fixed mode: channel 0 is highest priority, `NUM_CH-1` lowest.
- Rotating mode: pointer `topPtr` (CH_W bits) names the highest-priority channel; priority descends by increasing index, wrapping at `NUM_CH-1 → 0`.
  - On completed service of channel k, `topPtr <= (k==NUM_CH-1) ? 0 : k+1`. This uses explicit wrap, so it is valid for non-power-of-2 `NUM_CH`.
  - While `rotatingPriority == 0`, `topPtr` is held at 0, so switching modes restarts from channel 0.
- `ctrlDisable` raised in SERVE does not abort the current service; it only blocks the next one.
- Requests changing during SERVE do not change `activeCh`.

## Timing
- Reset values: state IDLE, `reqReg=0`, `topPtr=0`, `HRQ=0`, `grantValid=0`, `activeCh=0`, `DACK` at its inactive level.
  - Reset mid-service drops `HRQ` and `DACK` immediately (asynchronously), with no rotation.
- `DREQ` valid before edge 0 → `reqReg` set at edge 0 → `HRQ=1` after edge 1 (2-cycle latency).
- `HLDA` sampled high at edge m → `DACK`, `grantValid`, `activeCh` valid after edge m.
- `xferDone` at edge p → `DACK` inactive, `HRQ=0`, `topPtr` updated after edge p.
  - Next `HRQ` no earlier than after edge p+1: at least one idle cycle with `HRQ` low.
- A request removed before edge 0 is never seen. There is no minimum pulse width beyond one sampled edge.

## Configuration
- `DMA_ROTATING_PRIORITY_EN` defined: rotating mode and `topPtr` are as above.
- Undefined: `topPtr` logic is not built and `rotatingPriority` is ignored. Arbitration is always fixed (channel 0 highest).

## Structure
- Shared package `DmaPackage` holds:
  - enum `arb_state_e {ARB_IDLE, ARB_REQ, ARB_SERVE}`;
  - constant `DMA_MAX_CH = 8`;
  - function `dma_wrap_inc` (modulo increment).
- One sub-module, `dma_rr_pick`, parametrised by `NUM_CH`, purely combinational:
  - inputs `req`, `topPtr`;
  - outputs `winner` index and `anyReq`.
  - Fixed mode drives `topPtr = 0`.

## Test plan
- `NUM_CH=4`, fixed mode: `reqReg=4'b1010`, `HLDA` high → `activeCh=1`, `DACK=4'b0010` (active-high); `xferDone` → next grant channel 3.
- Rotating mode: channels 0..3 all requesting, complete four services → grant order 0,1,2,3,0 and `topPtr` sequence 1,2,3,0.
- `dreqActiveLow=1`, `DREQ=4'b1110`, `maskBits=4'b0001`, `swRequest=0` → no `HRQ`. Then set `swRequest=4'b0001` → `HRQ` after 2 cycles, grant channel 0.
- `dackActiveHigh=0`, grant channel 2 → `DACK=4'b1011`. `HLDA` dropped mid-SERVE → `DACK=4'b1111`, `HRQ=0`, `topPtr` unchanged.
- `NUM_CH=3` rotating: service channel 2 → `topPtr=0` (wrap). Assert `RESET` during SERVE → `HRQ=0` and `DACK` inactive without waiting for a clock edge.
